// File: rtl/hdmi_data_island_receiver_if.sv
// rtl/hdmi_data_island_receiver_if.sv - decoded data-island packet bundle
// master: the receiver drives packet_valid, header, sub, ecc_ok, error flags,
//         hsync/vsync and in_island.
// slave:  a packet parser or checker consumes the same signals.
interface hdmi_data_island_receiver_if;
    logic             packet_valid;
    logic [31:0]      header;
    logic [3:0][63:0] sub;
    logic [4:0]       ecc_ok;
    logic             terc4_error;
    logic             framing_error;
    logic             island_error;
    logic             hsync;
    logic             vsync;
    logic             in_island;

    modport master (
        output packet_valid, header, sub, ecc_ok, terc4_error, framing_error,
        output island_error, hsync, vsync, in_island
    );

    modport slave (
        input packet_valid, header, sub, ecc_ok, terc4_error, framing_error,
        input island_error, hsync, vsync, in_island
    );
endinterface

// File: rtl/hdmi_data_island_receiver.sv
// rtl/hdmi_data_island_receiver.sv - HDMI data-island depacketizer with TERC4 decode and BCH check
// clk_pixel          pixel clock, one 10-bit symbol per channel per cycle
// reset_n            asynchronous active-low reset
// tmds_0/1/2         channel 0..2 TMDS symbols
// pkt (master)       packet_valid strobe, header/sub fields, ecc_ok, error flags,
//                    island_error pulse, hsync/vsync, in_island
module hdmi_data_island_receiver #(
    parameter int MAX_PACKETS = 18
) (
    input  logic                               clk_pixel,
    input  logic                               reset_n,
    input  logic [9:0]                         tmds_0,
    input  logic [9:0]                         tmds_1,
    input  logic [9:0]                         tmds_2,
    hdmi_data_island_receiver_if.master        pkt
);
    localparam logic [9:0] GB_SYM = 10'b0100110011;
    localparam int         NPKT_W = $clog2(MAX_PACKETS + 1);

    typedef enum logic [1:0] {IDLE, LEAD_GB, PACKET, TRAIL_GB} state_t;

    // Returns {valid, value}; unknown symbols decode to value 0 with valid low.
    function automatic logic [4:0] terc4_decode(input logic [9:0] sym);
        case (sym)
            10'b1010011100: terc4_decode = 5'h10;
            10'b1001100011: terc4_decode = 5'h11;
            10'b1011100100: terc4_decode = 5'h12;
            10'b1011100010: terc4_decode = 5'h13;
            10'b0101110001: terc4_decode = 5'h14;
            10'b0100011110: terc4_decode = 5'h15;
            10'b0110001110: terc4_decode = 5'h16;
            10'b0100111100: terc4_decode = 5'h17;
            10'b1011001100: terc4_decode = 5'h18;
            10'b0100111001: terc4_decode = 5'h19;
            10'b0110011100: terc4_decode = 5'h1A;
            10'b1011000110: terc4_decode = 5'h1B;
            10'b1010001110: terc4_decode = 5'h1C;
            10'b1001110001: terc4_decode = 5'h1D;
            10'b0101100011: terc4_decode = 5'h1E;
            10'b1011000011: terc4_decode = 5'h1F;
            default:        terc4_decode = 5'h00;
        endcase
    endfunction

    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic b);
        bch_step = (e >> 1) ^ ((e[0] ^ b) ? 8'b10000011 : 8'h00);
    endfunction

    state_t            state, state_nxt;
    logic [4:0]        dec0, dec1, dec2;
    logic              sym_err, is_gb, data_ok, first, decide, pkt_sym;
    logic              abort, take_sym;
    logic [4:0]        cnt;
    logic [NPKT_W-1:0] npkt;
    logic [30:0]       hdr_sh;
    logic [3:0][61:0]  sub_sh;
    logic [7:0]        ecc_h, ecc_h_nxt;
    logic [3:0][7:0]   ecc_s, ecc_s_nxt;
    logic              terc_st, frame_st, terc_now, frame_now;
    logic [31:0]       hdr_nxt;
    logic [3:0][63:0]  sub_nxt;
    logic [4:0]        ecc_match;

    assign dec0 = terc4_decode(tmds_0);
    assign dec1 = terc4_decode(tmds_1);
    assign dec2 = terc4_decode(tmds_2);

    assign sym_err = ~(dec0[4] & dec1[4] & dec2[4]);
    assign is_gb   = (tmds_1 == GB_SYM) && (tmds_2 == GB_SYM) && dec0[4] && (dec0[3:2] == 2'b11);
    assign data_ok = dec1[4] & dec2[4];
    assign first   = (cnt == 5'd0);
    // cnt wraps to 0 after each packet; with npkt non-zero that symbol is the
    // one that decides between another packet, a trailing guard band or abort.
    assign decide  = (state == PACKET) && first && (npkt != '0);
    assign pkt_sym = (state == PACKET) && (state_nxt == PACKET);

    // Error flags are sticky within a packet and restart at cnt 0.
    assign terc_now  = (!first & terc_st) | sym_err;
    assign frame_now = (!first & frame_st) | (first ? dec0[3] : !dec0[3]);

    assign hdr_nxt = {dec0[2], hdr_sh};

    always_comb begin
        sub_nxt   = '0;
        ecc_h_nxt = ecc_h;
        ecc_s_nxt = ecc_s;
        for (int k = 0; k < 4; k++) begin
            sub_nxt[k] = {dec2[k], dec1[k], sub_sh[k]};
        end
        if (cnt <= 5'd23) begin
            ecc_h_nxt = bch_step(first ? 8'h00 : ecc_h, dec0[2]);
        end
        if (cnt <= 5'd27) begin
            for (int k = 0; k < 4; k++) begin
                ecc_s_nxt[k] = bch_step(bch_step(first ? 8'h00 : ecc_s[k], dec1[k]), dec2[k]);
            end
        end
    end

    // Parity bytes arrive last, so at cnt 31 the ECC registers are already final.
    always_comb begin
        ecc_match    = '0;
        ecc_match[0] = (ecc_h == hdr_nxt[31:24]);
        for (int k = 0; k < 4; k++) begin
            ecc_match[k+1] = (ecc_s[k] == sub_nxt[k][63:56]);
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        take_sym  = 1'b0;
        case (state)
            IDLE: begin
                if (is_gb) begin
                    state_nxt = LEAD_GB;
                    take_sym  = 1'b1;
                end
            end
            LEAD_GB: begin
                if (is_gb) begin
                    state_nxt = PACKET;
                    take_sym  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            PACKET: begin
                take_sym = 1'b1;
                if (decide) begin
                    if (is_gb) begin
                        state_nxt = TRAIL_GB;
                    end else if (!data_ok || (npkt == NPKT_W'(MAX_PACKETS))) begin
                        state_nxt = IDLE;
                        abort     = 1'b1;
                        take_sym  = 1'b0;
                    end
                end
            end
            TRAIL_GB: begin
                state_nxt = IDLE;
                if (is_gb) begin
                    take_sym = 1'b1;
                end else begin
                    abort = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign pkt.in_island = (state != IDLE);

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cnt               <= '0;
            npkt              <= '0;
            hdr_sh            <= '0;
            sub_sh            <= '0;
            ecc_h             <= '0;
            ecc_s             <= '0;
            terc_st           <= 1'b0;
            frame_st          <= 1'b0;
            pkt.packet_valid  <= 1'b0;
            pkt.header        <= '0;
            pkt.sub           <= '0;
            pkt.ecc_ok        <= '0;
            pkt.terc4_error   <= 1'b0;
            pkt.framing_error <= 1'b0;
            pkt.island_error  <= 1'b0;
            pkt.hsync         <= 1'b0;
            pkt.vsync         <= 1'b0;
        end else begin
            pkt.packet_valid <= 1'b0;
            pkt.island_error <= abort;
            if (take_sym) begin
                pkt.hsync <= dec0[0];
                pkt.vsync <= dec0[1];
            end
            if (pkt_sym) begin
                cnt      <= cnt + 5'd1;
                hdr_sh   <= hdr_nxt[31:1];
                for (int k = 0; k < 4; k++) begin
                    sub_sh[k] <= sub_nxt[k][63:2];
                end
                ecc_h    <= ecc_h_nxt;
                ecc_s    <= ecc_s_nxt;
                terc_st  <= terc_now;
                frame_st <= frame_now;
                if (cnt == 5'd31) begin
                    npkt              <= npkt + 1'b1;
                    pkt.packet_valid  <= 1'b1;
                    pkt.header        <= hdr_nxt;
                    pkt.sub           <= sub_nxt;
                    pkt.ecc_ok        <= ecc_match;
                    pkt.terc4_error   <= terc_now;
                    pkt.framing_error <= frame_now;
                end
            end else begin
                cnt <= '0;
                if (state != PACKET) begin
                    npkt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_hdmi_data_island_receiver.sv
// tb/tb_hdmi_data_island_receiver.sv - directed self-checking bench for hdmi_data_island_receiver
module tb_hdmi_data_island_receiver;
    localparam int         MAXP    = 18;
    localparam logic [9:0] GB_SYM  = 10'b0100110011;
    localparam logic [9:0] CTL_SYM = 10'b1101010100;
    localparam logic [9:0] VGB_SYM = 10'b1011001100;

    logic       clk_pixel = 1'b0;
    logic       reset_n;
    logic [9:0] tmds_0, tmds_1, tmds_2;

    hdmi_data_island_receiver_if bus();

    hdmi_data_island_receiver #(.MAX_PACKETS(MAXP)) dut (
        .clk_pixel (clk_pixel),
        .reset_n   (reset_n),
        .tmds_0    (tmds_0),
        .tmds_1    (tmds_1),
        .tmds_2    (tmds_2),
        .pkt       (bus)
    );

    always #5 clk_pixel = ~clk_pixel;

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int pv_cnt = 0;
    int pv_q[$];

    always @(negedge clk_pixel) begin
        cyc++;
        if (bus.packet_valid) begin
            pv_cnt++;
            pv_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] enc(input logic [3:0] d);
        case (d)
            4'h0: return 10'b1010011100;
            4'h1: return 10'b1001100011;
            4'h2: return 10'b1011100100;
            4'h3: return 10'b1011100010;
            4'h4: return 10'b0101110001;
            4'h5: return 10'b0100011110;
            4'h6: return 10'b0110001110;
            4'h7: return 10'b0100111100;
            4'h8: return 10'b1011001100;
            4'h9: return 10'b0100111001;
            4'hA: return 10'b0110011100;
            4'hB: return 10'b1011000110;
            4'hC: return 10'b1010001110;
            4'hD: return 10'b1001110001;
            4'hE: return 10'b0101100011;
            4'hF: return 10'b1011000011;
            default: return 10'b0;
        endcase
    endfunction

    function automatic logic [7:0] bch(input logic [55:0] d, input int n);
        logic [7:0] e;
        e = 8'h00;
        for (int i = 0; i < n; i++) begin
            e = (e >> 1) ^ ((e[0] ^ d[i]) ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    function automatic logic [31:0] mk_hdr(input logic [23:0] d);
        return {bch({32'h0, d}, 24), d};
    endfunction

    function automatic logic [63:0] mk_sub(input logic [55:0] d);
        return {bch(d, 56), d};
    endfunction

    task automatic drive_sym(input logic [9:0] s0, input logic [9:0] s1, input logic [9:0] s2);
        tmds_0 = s0;
        tmds_1 = s1;
        tmds_2 = s2;
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic gb(input logic hs, input logic vs);
        drive_sym(enc({2'b11, vs, hs}), GB_SYM, GB_SYM);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_sym(CTL_SYM, CTL_SYM, CTL_SYM);
    endtask

    task automatic send_pkt(input logic [31:0] h, input logic [3:0][63:0] s,
                            input logic hs, input logic vs,
                            input int bad_ch1_at, input int bad_mark_at, input int n);
        logic [3:0] d0, d1, d2;
        for (int i = 0; i < n; i++) begin
            d0 = {(i != 0), h[i], vs, hs};
            if (i == bad_mark_at) d0[3] = ~d0[3];
            for (int k = 0; k < 4; k++) begin
                d1[k] = s[k][2*i];
                d2[k] = s[k][2*i+1];
            end
            drive_sym(enc(d0), (i == bad_ch1_at) ? 10'h3FF : enc(d1), enc(d2));
        end
    endtask

    logic [31:0]      h_acr, h_b;
    logic [63:0]      sd_acr;
    logic [3:0][63:0] s_acr, s_bad, s_b;
    logic [3:0][63:0] zero_sub;
    int               pv_base;

    initial begin
        zero_sub = '0;
        reset_n  = 1'b0;
        tmds_0   = CTL_SYM;
        tmds_1   = CTL_SYM;
        tmds_2   = CTL_SYM;
        repeat (2) @(posedge clk_pixel);
        #1;
        check_eq("rst_pv", bus.packet_valid, 0);
        check_eq("rst_hdr", bus.header, 0);
        check_eq("rst_sub", bus.sub, 0);
        check_eq("rst_flags", {bus.ecc_ok, bus.terc4_error, bus.framing_error, bus.island_error,
                               bus.hsync, bus.vsync, bus.in_island}, 0);
        reset_n = 1'b1;
        idle(2);

        // Null packet island
        gb(1'b1, 1'b0);
        check_eq("null_lead_in", bus.in_island, 1);
        gb(1'b1, 1'b0);
        send_pkt(32'h0, zero_sub, 1'b1, 1'b0, -1, -1, 32);
        check_eq("null_pv", bus.packet_valid, 1);
        check_eq("null_hdr", bus.header, 0);
        check_eq("null_sub", bus.sub, 0);
        check_eq("null_ecc", bus.ecc_ok, 5'b11111);
        check_eq("null_err", {bus.terc4_error, bus.framing_error}, 0);
        check_eq("null_sync", {bus.vsync, bus.hsync}, 2'b01);
        gb(1'b1, 1'b0);
        check_eq("null_pv_1cyc", bus.packet_valid, 0);
        check_eq("null_trail1", bus.in_island, 1);
        gb(1'b1, 1'b0);
        check_eq("null_trail2", bus.in_island, 0);
        check_eq("null_no_ierr", bus.island_error, 0);
        idle(1);
        check_eq("hsync_hold", bus.hsync, 1);

        // ACR packet: N = 6144, CTS = 25200, then same with sub[2] bit 5 flipped
        h_acr  = mk_hdr(24'h000001);
        sd_acr = mk_sub(56'h00180070620000);
        s_acr  = {sd_acr, sd_acr, sd_acr, sd_acr};
        s_bad  = s_acr;
        s_bad[2][5] = ~s_bad[2][5];
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        send_pkt(h_acr, s_acr, 1'b0, 1'b0, -1, -1, 32);
        check_eq("acr_pv", bus.packet_valid, 1);
        check_eq("acr_hdr", bus.header, h_acr);
        check_eq("acr_hb0", bus.header[7:0], 8'h01);
        check_eq("acr_sub", bus.sub, s_acr);
        check_eq("acr_n", {bus.sub[0][35:32], bus.sub[0][47:40], bus.sub[0][55:48]}, 20'd6144);
        check_eq("acr_cts", {bus.sub[3][11:8], bus.sub[3][23:16], bus.sub[3][31:24]}, 20'd25200);
        check_eq("acr_ecc", bus.ecc_ok, 5'b11111);
        send_pkt(h_acr, s_bad, 1'b0, 1'b0, -1, -1, 32);
        check_eq("acr_bad_pv", bus.packet_valid, 1);
        check_eq("acr_bad_sub", bus.sub, s_bad);
        check_eq("acr_bad_ecc", bus.ecc_ok, 5'b10111);
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        check_eq("acr_out", bus.in_island, 0);
        idle(2);

        // Three packets back to back
        pv_q.delete();
        gb(1'b0, 1'b1);
        gb(1'b0, 1'b1);
        for (int p = 0; p < 3; p++) begin
            h_b = mk_hdr(24'h0A0B00 + 24'(p * 17));
            for (int k = 0; k < 4; k++) s_b[k] = mk_sub(56'h11223344556600 + 56'(p * 256 + k));
            send_pkt(h_b, s_b, 1'b0, 1'b1, -1, -1, 32);
            check_eq($sformatf("b2b_hdr%0d", p), bus.header, h_b);
            check_eq($sformatf("b2b_sub%0d", p), bus.sub, s_b);
            check_eq($sformatf("b2b_ecc%0d", p), bus.ecc_ok, 5'b11111);
        end
        gb(1'b0, 1'b1);
        gb(1'b0, 1'b1);
        idle(1);
        check_eq("b2b_count", pv_q.size(), 3);
        if (pv_q.size() == 3) begin
            check_eq("b2b_gap01", pv_q[1] - pv_q[0], 32);
            check_eq("b2b_gap12", pv_q[2] - pv_q[1], 32);
        end
        check_eq("b2b_vsync", {bus.vsync, bus.hsync}, 2'b10);

        // Malformed symbols
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        send_pkt(h_acr, s_acr, 1'b0, 1'b0, 7, -1, 32);
        check_eq("terc_err", {bus.packet_valid, bus.terc4_error, bus.framing_error}, 3'b110);
        send_pkt(h_acr, s_acr, 1'b0, 1'b0, -1, 0, 32);
        check_eq("frame_err", {bus.packet_valid, bus.terc4_error, bus.framing_error}, 3'b101);
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        idle(1);

        // MAX_PACKETS + 1 packets
        pv_base = pv_cnt;
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        for (int p = 0; p < MAXP; p++) send_pkt(32'h0, zero_sub, 1'b0, 1'b0, -1, -1, 32);
        drive_sym(enc(4'h0), enc(4'h0), enc(4'h0));
        check_eq("max_ierr", bus.island_error, 1);
        check_eq("max_idle", bus.in_island, 0);
        idle(1);
        check_eq("max_ierr_pulse", bus.island_error, 0);
        check_eq("max_pv_count", pv_cnt - pv_base, MAXP);

        // Video guard band after a packet
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        send_pkt(h_acr, s_acr, 1'b0, 1'b0, -1, -1, 32);
        drive_sym(VGB_SYM, GB_SYM, VGB_SYM);
        check_eq("vgb_ierr", bus.island_error, 1);
        check_eq("vgb_idle", bus.in_island, 0);

        // Restart, then reset mid-packet at cnt 15
        gb(1'b1, 1'b1);
        check_eq("restart_in", bus.in_island, 1);
        gb(1'b1, 1'b1);
        pv_base = pv_cnt;
        send_pkt(h_b, s_b, 1'b1, 1'b1, -1, -1, 16);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_hdr", bus.header, 0);
        check_eq("mid_rst_sub", bus.sub, 0);
        check_eq("mid_rst_flags", {bus.ecc_ok, bus.packet_valid, bus.hsync, bus.vsync, bus.in_island}, 0);
        send_pkt(h_b, s_b, 1'b1, 1'b1, -1, -1, 2);
        reset_n = 1'b1;
        send_pkt(h_b, s_b, 1'b1, 1'b1, -1, -1, 16);
        idle(2);
        check_eq("mid_rst_no_pv", pv_cnt - pv_base, 0);
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        send_pkt(h_acr, s_acr, 1'b0, 1'b0, -1, -1, 32);
        check_eq("post_rst_pv", bus.packet_valid, 1);
        check_eq("post_rst_hdr", bus.header, h_acr);
        check_eq("post_rst_sub", bus.sub, s_acr);
        check_eq("post_rst_ecc", bus.ecc_ok, 5'b11111);
        gb(1'b0, 1'b0);
        gb(1'b0, 1'b0);
        check_eq("post_rst_out", bus.in_island, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
